pe_sequencer: RTL and testbench

Control unit that drives one background-removal processing element (PE) through a full frame in two passes. Pass 1 streams pixel blocks from frame memory into the PE, issues sum requests and accumulates the per-block RGB sums into a frame mean. Pass 2 replays the blocks with that mean as the expected background colour, issues background-removal requests and writes the PE results back to frame memory. It sits between the frame memory and the PE, acting as initiator of the PE's Start/Done/Ack protocol.

---
 rtl/pe_sequencer_pkg.sv | 43 ++++
 rtl/pe_rgb_accum.sv | 45 ++++
 rtl/pe_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_pe_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_sequencer_pkg.sv
// Shared definitions for the background-removal PE sequencer: state
// encoding, channel widths and helpers for the packed pixel buses.
package pe_sequencer_pkg;

  localparam int PIX_W   = 8;
  localparam int SUM_W   = 16;
  localparam int MAX_PIX = 16;

  // One-hot sequencer states.
  typedef enum logic [13:0] {
    IDLE   = 14'h0001,
    S_RD   = 14'h0002,
    S_LOAD = 14'h0004,
    S_GO   = 14'h0008,
    S_WAIT = 14'h0010,
    S_ACK  = 14'h0020,
    MEAN   = 14'h0040,
    B_RD   = 14'h0080,
    B_LOAD = 14'h0100,
    B_GO   = 14'h0200,
    B_WAIT = 14'h0400,
    B_ACK  = 14'h0800,
    DONE   = 14'h1000,
    ERR    = 14'h2000
  } state_t;

  // Extract pixel k from a packed bus (pixel k lives at bits [8k+7:8k]).
  function automatic logic [PIX_W-1:0] pix_get(input logic [MAX_PIX*PIX_W-1:0] bus,
                                                input int unsigned k);
    return bus[k*PIX_W +: PIX_W];
  endfunction

  // Return the packed bus with pixel k replaced by px.
  function automatic logic [MAX_PIX*PIX_W-1:0] pix_set(input logic [MAX_PIX*PIX_W-1:0] bus,
                                                        input int unsigned k,
                                                        input logic [PIX_W-1:0] px);
    logic [MAX_PIX*PIX_W-1:0] res;
    res = bus;
    res[k*PIX_W +: PIX_W] = px;
    return res;
  endfunction

endpackage

// File: rtl/pe_rgb_accum.sv
// Three per-channel block-sum accumulators with synchronous clear/add and a
// truncating shift that turns the frame total into the mean colour.
module pe_rgb_accum
  import pe_sequencer_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int SHIFT = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             add,
  input  logic [SUM_W-1:0] sum_r,
  input  logic [SUM_W-1:0] sum_g,
  input  logic [SUM_W-1:0] sum_b,
  output logic [PIX_W-1:0] mean_r,
  output logic [PIX_W-1:0] mean_g,
  output logic [PIX_W-1:0] mean_b
);

  logic [ACC_W-1:0] acc_r, acc_g, acc_b;

  // Accumulate one block sum per channel; clear wins over add.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_r <= '0;
      acc_g <= '0;
      acc_b <= '0;
    end else if (clr) begin
      acc_r <= '0;
      acc_g <= '0;
      acc_b <= '0;
    end else if (add) begin
      acc_r <= acc_r + ACC_W'(sum_r);
      acc_g <= acc_g + ACC_W'(sum_g);
      acc_b <= acc_b + ACC_W'(sum_b);
    end
  end

  // Division by the pixel count of the frame is a plain right shift.
  assign mean_r = PIX_W'(acc_r >> SHIFT);
  assign mean_g = PIX_W'(acc_g >> SHIFT);
  assign mean_b = PIX_W'(acc_b >> SHIFT);

endmodule

// File: rtl/pe_sequencer.sv
// Two-pass frame sequencer for one background-removal PE: pass 1 gathers
// block sums into a frame mean, pass 2 removes the background block by block
// and writes the PE results back to frame memory.
module pe_sequencer
  import pe_sequencer_pkg::*;
#(
  parameter int PIX_LOG2 = 0,
  parameter int BLK_LOG2 = 4,
  parameter int TIMEOUT  = 255,
  localparam int NUM_PIXELS = 2 ** PIX_LOG2,
  localparam int NUM_BLOCKS = 2 ** BLK_LOG2,
  localparam int ADDR_W     = (BLK_LOG2 > 0) ? BLK_LOG2 : 1,
  localparam int BUS_W      = PIX_W * NUM_PIXELS
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  input  logic [17:0]       threshold,
  input  logic [PIX_W-1:0]  bg_r,
  input  logic [PIX_W-1:0]  bg_g,
  input  logic [PIX_W-1:0]  bg_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [BUS_W-1:0]  mem_rd_r,
  input  logic [BUS_W-1:0]  mem_rd_g,
  input  logic [BUS_W-1:0]  mem_rd_b,
  output logic              mem_wr_en,
  output logic [BUS_W-1:0]  mem_wr_r,
  output logic [BUS_W-1:0]  mem_wr_g,
  output logic [BUS_W-1:0]  mem_wr_b,
  output logic [BUS_W-1:0]  pe_r,
  output logic [BUS_W-1:0]  pe_g,
  output logic [BUS_W-1:0]  pe_b,
  output logic [PIX_W-1:0]  pe_exp_r,
  output logic [PIX_W-1:0]  pe_exp_g,
  output logic [PIX_W-1:0]  pe_exp_b,
  output logic [17:0]       pe_threshold,
  output logic [PIX_W-1:0]  pe_bg_r,
  output logic [PIX_W-1:0]  pe_bg_g,
  output logic [PIX_W-1:0]  pe_bg_b,
  output logic              pe_start_sum,
  output logic              pe_start_bg,
  output logic              pe_ack,
  input  logic              pe_qi,
  input  logic              pe_qsd,
  input  logic              pe_qbgd,
  input  logic [SUM_W-1:0]  pe_sum_r,
  input  logic [SUM_W-1:0]  pe_sum_g,
  input  logic [SUM_W-1:0]  pe_sum_b,
  input  logic [BUS_W-1:0]  pe_out_r,
  input  logic [BUS_W-1:0]  pe_out_g,
  input  logic [BUS_W-1:0]  pe_out_b
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] blk;
  logic [WD_W-1:0]   wd;
  logic              last_blk, wd_expired, cur_waiting, next_waiting;
  logic              acc_clr, acc_add, blk_clr, blk_inc, load_pix, load_mean;
  logic [PIX_W-1:0]  mean_r, mean_g, mean_b;

  assign last_blk     = (BLK_LOG2 == 0) || (blk == ADDR_W'(NUM_BLOCKS - 1));
  assign wd_expired   = (wd == WD_W'(TIMEOUT));
  assign cur_waiting  = state inside {S_GO, S_WAIT, B_GO, B_WAIT};
  assign next_waiting = state_next inside {S_GO, S_WAIT, B_GO, B_WAIT};

  pe_rgb_accum #(
    .ACC_W (SUM_W + BLK_LOG2),
    .SHIFT (PIX_LOG2 + BLK_LOG2)
  ) u_accum (
    .Clk    (Clk),
    .Reset  (Reset),
    .clr    (acc_clr),
    .add    (acc_add),
    .sum_r  (pe_sum_r),
    .sum_g  (pe_sum_g),
    .sum_b  (pe_sum_b),
    .mean_r (mean_r),
    .mean_g (mean_g),
    .mean_b (mean_b)
  );

  // State register; an asynchronous reset aborts any frame in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Watchdog restarts on every entry into a GO/WAIT state and counts while there.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                    wd <= '0;
    else if (next_waiting && state_next != state) wd <= '0;
    else if (cur_waiting)                         wd <= wd + 1'b1;
  end

  // Block counter, PE pixel/mean holding registers and forwarded PE settings.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blk          <= '0;
      pe_r         <= '0;
      pe_g         <= '0;
      pe_b         <= '0;
      pe_exp_r     <= '0;
      pe_exp_g     <= '0;
      pe_exp_b     <= '0;
      pe_threshold <= '0;
      pe_bg_r      <= '0;
      pe_bg_g      <= '0;
      pe_bg_b      <= '0;
    end else begin
      pe_threshold <= threshold;
      pe_bg_r      <= bg_r;
      pe_bg_g      <= bg_g;
      pe_bg_b      <= bg_b;
      if (blk_clr)      blk <= '0;
      else if (blk_inc) blk <= blk + 1'b1;
      if (load_pix) begin
        pe_r <= mem_rd_r;
        pe_g <= mem_rd_g;
        pe_b <= mem_rd_b;
      end
      if (load_mean) begin
        pe_exp_r <= mean_r;
        pe_exp_g <= mean_g;
        pe_exp_b <= mean_b;
      end
    end
  end

  // Next-state and per-state strobes; each pulse lasts one state visit.
  always_comb begin
    state_next   = state;
    Busy         = 1'b1;
    Done         = 1'b0;
    Error        = 1'b0;
    mem_addr     = '0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    mem_wr_r     = '0;
    mem_wr_g     = '0;
    mem_wr_b     = '0;
    pe_start_sum = 1'b0;
    pe_start_bg  = 1'b0;
    pe_ack       = 1'b0;
    acc_clr      = 1'b0;
    acc_add      = 1'b0;
    blk_clr      = 1'b0;
    blk_inc      = 1'b0;
    load_pix     = 1'b0;
    load_mean    = 1'b0;
    unique case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          acc_clr    = 1'b1;
          blk_clr    = 1'b1;
          state_next = S_RD;
        end
      end
      S_RD: begin
        mem_rd_en  = 1'b1;
        mem_addr   = blk;
        state_next = S_LOAD;
      end
      S_LOAD: begin
        load_pix   = 1'b1;
        state_next = S_GO;
      end
      S_GO: begin
        if (pe_qi) begin
          pe_start_sum = 1'b1;
          state_next   = S_WAIT;
        end else if (wd_expired) begin
          state_next = ERR;
        end
      end
      S_WAIT: begin
        if (pe_qsd)          state_next = S_ACK;
        else if (wd_expired) state_next = ERR;
      end
      S_ACK: begin
        acc_add = 1'b1;
        pe_ack  = 1'b1;
        if (last_blk) begin
          state_next = MEAN;
        end else begin
          blk_inc    = 1'b1;
          state_next = S_RD;
        end
      end
      MEAN: begin
        load_mean  = 1'b1;
        blk_clr    = 1'b1;
        state_next = B_RD;
      end
      B_RD: begin
        mem_rd_en  = 1'b1;
        mem_addr   = blk;
        state_next = B_LOAD;
      end
      B_LOAD: begin
        load_pix   = 1'b1;
        state_next = B_GO;
      end
      B_GO: begin
        if (pe_qi) begin
          pe_start_bg = 1'b1;
          state_next  = B_WAIT;
        end else if (wd_expired) begin
          state_next = ERR;
        end
      end
      B_WAIT: begin
        if (pe_qbgd)         state_next = B_ACK;
        else if (wd_expired) state_next = ERR;
      end
      B_ACK: begin
        mem_wr_en = 1'b1;
        mem_addr  = blk;
        mem_wr_r  = pe_out_r;
        mem_wr_g  = pe_out_g;
        mem_wr_b  = pe_out_b;
        pe_ack    = 1'b1;
        if (last_blk) begin
          state_next = DONE;
        end else begin
          blk_inc    = 1'b1;
          state_next = B_RD;
        end
      end
      DONE: begin
        Busy = 1'b0;
        Done = 1'b1;
        if (!Start) state_next = IDLE;
      end
      ERR: begin
        Busy  = 1'b0;
        Error = 1'b1;
        if (!Start) state_next = IDLE;
      end
      default: begin
        Busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer with a behavioural PE and frame memory.
`timescale 1ns/1ps
module tb_pe_sequencer;

  localparam int TO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start_b, qi_hold, never_done;
  logic [17:0] threshold;
  logic [7:0]  bg_r, bg_g, bg_b;
  int          n_chk, n_fail;

  // ---------------- instance A: 4 blocks of 1 pixel ----------------
  logic        busy, done, error, mem_rd_en, mem_wr_en;
  logic [1:0]  mem_addr;
  logic [7:0]  rd_r, rd_g, rd_b, wr_r, wr_g, wr_b, pe_r, pe_g, pe_b;
  logic [7:0]  exp_r, exp_g, exp_b, pbg_r, pbg_g, pbg_b;
  logic [17:0] pthr;
  logic        start_sum, start_bg, ack, qi, qi_m, qsd, qbgd, mode_bg;
  logic [15:0] sum_r, sum_g, sum_b;
  logic [7:0]  out_r, out_g, out_b;
  logic [7:0]  mem_r [4], mem_g [4], mem_b [4];
  logic [7:0]  wl_addr [64];
  logic [23:0] wl_data [64];
  int          pe_cnt, n_ss, n_sb, n_wr;

  pe_sequencer #(.PIX_LOG2(0), .BLK_LOG2(2), .TIMEOUT(TO)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Busy(busy), .Done(done), .Error(error),
    .threshold(threshold), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_r(rd_r), .mem_rd_g(rd_g), .mem_rd_b(rd_b),
    .mem_wr_en(mem_wr_en), .mem_wr_r(wr_r), .mem_wr_g(wr_g), .mem_wr_b(wr_b),
    .pe_r(pe_r), .pe_g(pe_g), .pe_b(pe_b),
    .pe_exp_r(exp_r), .pe_exp_g(exp_g), .pe_exp_b(exp_b),
    .pe_threshold(pthr), .pe_bg_r(pbg_r), .pe_bg_g(pbg_g), .pe_bg_b(pbg_b),
    .pe_start_sum(start_sum), .pe_start_bg(start_bg), .pe_ack(ack),
    .pe_qi(qi), .pe_qsd(qsd), .pe_qbgd(qbgd),
    .pe_sum_r(sum_r), .pe_sum_g(sum_g), .pe_sum_b(sum_b),
    .pe_out_r(out_r), .pe_out_g(out_g), .pe_out_b(out_b)
  );

  assign qi    = qi_m & ~qi_hold;
  assign out_r = 8'd0;
  assign out_g = 8'd255;
  assign out_b = 8'd0;

  // Frame memory A: registered read, data valid the cycle after mem_rd_en.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      rd_r <= mem_r[mem_addr];
      rd_g <= mem_g[mem_addr];
      rd_b <= mem_b[mem_addr];
    end
  end

  // PE model A: sums are the single pixel, results after two cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qi_m <= 1'b1; qsd <= 1'b0; qbgd <= 1'b0; pe_cnt <= 0; mode_bg <= 1'b0;
      sum_r <= '0; sum_g <= '0; sum_b <= '0;
    end else begin
      if (start_sum || start_bg) begin
        qi_m    <= 1'b0;
        pe_cnt  <= 2;
        mode_bg <= start_bg;
        sum_r   <= {8'd0, pe_r};
        sum_g   <= {8'd0, pe_g};
        sum_b   <= {8'd0, pe_b};
      end else if (pe_cnt == 1) begin
        pe_cnt <= 0;
        if (!never_done) begin
          if (mode_bg) qbgd <= 1'b1;
          else         qsd  <= 1'b1;
        end
      end else if (pe_cnt > 1) begin
        pe_cnt <= pe_cnt - 1;
      end
      if (ack) begin
        qsd  <= 1'b0;
        qbgd <= 1'b0;
        qi_m <= 1'b1;
      end
    end
  end

  // Pulse counters and write log for instance A.
  always @(posedge clk) begin
    if (!rst) begin
      if (start_sum) n_ss <= n_ss + 1;
      if (start_bg)  n_sb <= n_sb + 1;
      if (mem_wr_en) begin
        wl_addr[n_wr % 64] <= {6'd0, mem_addr};
        wl_data[n_wr % 64] <= {wr_r, wr_g, wr_b};
        n_wr <= n_wr + 1;
      end
    end
  end

  // ---------------- instance B: 16 blocks, all-255 frame ----------------
  logic        busy_b, done_b, error_b, rd_en_b, wr_en_b;
  logic [3:0]  addr_b;
  logic [7:0]  wr_r_b, wr_g_b, wr_b_b, pe_r_b, pe_g_b, pe_b_b;
  logic [7:0]  exp_r_b, exp_g_b, exp_b_b, pbg_r_b, pbg_g_b, pbg_b_b;
  logic [17:0] pthr_b;
  logic        ss_b, sb_b, ack_b, qi_b, qsd_b, qbgd_b;
  logic [15:0] sum_r_b, sum_g_b, sum_b_b;

  pe_sequencer #(.PIX_LOG2(0), .BLK_LOG2(4), .TIMEOUT(TO)) dut_b (
    .Clk(clk), .Reset(rst), .Start(start_b), .Busy(busy_b), .Done(done_b), .Error(error_b),
    .threshold(threshold), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .mem_addr(addr_b), .mem_rd_en(rd_en_b),
    .mem_rd_r(8'hFF), .mem_rd_g(8'hFF), .mem_rd_b(8'hFF),
    .mem_wr_en(wr_en_b), .mem_wr_r(wr_r_b), .mem_wr_g(wr_g_b), .mem_wr_b(wr_b_b),
    .pe_r(pe_r_b), .pe_g(pe_g_b), .pe_b(pe_b_b),
    .pe_exp_r(exp_r_b), .pe_exp_g(exp_g_b), .pe_exp_b(exp_b_b),
    .pe_threshold(pthr_b), .pe_bg_r(pbg_r_b), .pe_bg_g(pbg_g_b), .pe_bg_b(pbg_b_b),
    .pe_start_sum(ss_b), .pe_start_bg(sb_b), .pe_ack(ack_b),
    .pe_qi(qi_b), .pe_qsd(qsd_b), .pe_qbgd(qbgd_b),
    .pe_sum_r(sum_r_b), .pe_sum_g(sum_g_b), .pe_sum_b(sum_b_b),
    .pe_out_r(pe_r_b), .pe_out_g(pe_g_b), .pe_out_b(pe_b_b)
  );

  // PE model B: answers one cycle after each start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qi_b <= 1'b1; qsd_b <= 1'b0; qbgd_b <= 1'b0;
      sum_r_b <= '0; sum_g_b <= '0; sum_b_b <= '0;
    end else begin
      if (ss_b) begin
        qi_b <= 1'b0; qsd_b <= 1'b1;
        sum_r_b <= {8'd0, pe_r_b}; sum_g_b <= {8'd0, pe_g_b}; sum_b_b <= {8'd0, pe_b_b};
      end
      if (sb_b) begin
        qi_b <= 1'b0; qbgd_b <= 1'b1;
      end
      if (ack_b) begin
        qi_b <= 1'b1; qsd_b <= 1'b0; qbgd_b <= 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k;
    k = 0;
    while (!done && k < bound) begin
      tick();
      k++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base_ss, base_sb, base_wr, k;
    logic stable, early;
    n_chk = 0; n_fail = 0; n_ss = 0; n_sb = 0; n_wr = 0;
    rst = 1'b1; start = 1'b0; start_b = 1'b0; qi_hold = 1'b0; never_done = 1'b0;
    threshold = 18'd1000; bg_r = 8'd0; bg_g = 8'd255; bg_b = 8'd0;
    mem_r[0] = 8'd10;  mem_r[1] = 8'd14;  mem_r[2] = 8'd12;  mem_r[3] = 8'd200;
    mem_g[0] = 8'd20;  mem_g[1] = 8'd20;  mem_g[2] = 8'd24;  mem_g[3] = 8'd200;
    mem_b[0] = 8'd30;  mem_b[1] = 8'd30;  mem_b[2] = 8'd30;  mem_b[3] = 8'd200;
    tick(); tick();

    // Reset state
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 0);
    check("rst_wr_en", {31'd0, mem_wr_en}, 0);
    check("rst_addr", {30'd0, mem_addr}, 0);
    check("rst_pulses", {29'd0, start_sum, start_bg, ack}, 0);
    check("rst_pe_rgb", {8'd0, pe_r, pe_g, pe_b}, 0);
    check("rst_exp", {8'd0, exp_r, exp_g, exp_b}, 0);
    check("rst_thr", {14'd0, pthr}, 0);
    rst = 1'b0;
    tick();
    check("thr_fwd", {14'd0, pthr}, 1000);

    // Frame 1: mean and write-back
    base_ss = n_ss; base_sb = n_sb; base_wr = n_wr;
    start = 1'b1;
    wait_done("f1_done", 500);
    check("f1_exp_r", {24'd0, exp_r}, 59);
    check("f1_exp_g", {24'd0, exp_g}, 66);
    check("f1_exp_b", {24'd0, exp_b}, 72);
    check("f1_n_start_sum", n_ss - base_ss, 4);
    check("f1_n_start_bg", n_sb - base_sb, 4);
    check("f1_n_wr", n_wr - base_wr, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("f1_wr_addr%0d", i), {24'd0, wl_addr[(base_wr + i) % 64]}, i);
      check($sformatf("f1_wr_data%0d", i), {8'd0, wl_data[(base_wr + i) % 64]}, 32'h0000FF00);
    end
    check("f1_busy_idle", {31'd0, busy}, 0);
    start = 1'b0;
    check("f1_done_hold", {31'd0, done}, 1);
    tick();
    check("f1_done_fall", {31'd0, done}, 0);

    // Frame 2: pe_qi held low before pass-2 block 1
    tick();
    base_sb = n_sb;
    start = 1'b1;
    k = 0;
    while (!(mem_wr_en && mem_addr == 2'd0) && k < 500) begin tick(); k++; end
    check("hold_b0_ack_seen", {31'd0, mem_wr_en}, 1);
    qi_hold = 1'b1;
    tick(); tick(); tick();
    check("hold_pe_r", {24'd0, pe_r}, 14);
    check("hold_pe_gb", {16'd0, pe_g, pe_b}, {16'd0, 8'd20, 8'd30});
    stable = 1'b1; early = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (pe_r !== 8'd14 || pe_g !== 8'd20 || pe_b !== 8'd30) stable = 1'b0;
      if (start_bg) early = 1'b1;
      tick();
    end
    check("hold_pe_stable", {31'd0, stable}, 1);
    check("hold_no_early_start", {31'd0, early}, 0);
    qi_hold = 1'b0;
    #1;
    check("hold_start_on_qi", {31'd0, start_bg}, 1);
    check("hold_pe_r_at_start", {24'd0, pe_r}, 14);
    tick();
    check("hold_start_one_cycle", {31'd0, start_bg}, 0);
    wait_done("hold_done", 500);
    check("hold_n_start_bg", n_sb - base_sb, 4);
    start = 1'b0;
    tick();

    // Frame 3: PE never signals sum-done -> watchdog
    tick();
    never_done = 1'b1;
    base_wr = n_wr;
    start = 1'b1;
    k = 0;
    while (!start_sum && k < 50) begin tick(); k++; end
    check("to_start_seen", {31'd0, start_sum}, 1);
    repeat (TO + 1) tick();
    check("to_not_yet", {31'd0, error}, 0);
    tick();
    check("to_error", {31'd0, error}, 1);
    check("to_busy_low", {31'd0, busy}, 0);
    check("to_no_writes", n_wr - base_wr, 0);
    start = 1'b0;
    tick();
    check("to_error_clear", {31'd0, error}, 0);
    never_done = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // Frame 4: reset during B_WAIT of block 2, then rerun
    base_wr = n_wr;
    start = 1'b1;
    k = 0;
    while (!(start_bg && pe_r == 8'd12) && k < 500) begin tick(); k++; end
    check("mid_b2_go_seen", {31'd0, start_bg}, 1);
    tick();
    check("mid_b2_wait_busy", {31'd0, busy}, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_busy", {31'd0, busy}, 0);
    check("mid_strobes", {28'd0, mem_rd_en, mem_wr_en, start_bg, ack}, 0);
    check("mid_addr", {30'd0, mem_addr}, 0);
    check("mid_pe_rgb", {8'd0, pe_r, pe_g, pe_b}, 0);
    check("mid_exp", {8'd0, exp_r, exp_g, exp_b}, 0);
    tick(); tick();
    check("mid_writes", n_wr - base_wr, 2);
    start = 1'b0;
    rst = 1'b0;
    tick();
    base_wr = n_wr;
    start = 1'b1;
    k = 0;
    while (!mem_rd_en && k < 20) begin tick(); k++; end
    check("rerun_rd_seen", {31'd0, mem_rd_en}, 1);
    check("rerun_first_addr", {30'd0, mem_addr}, 0);
    wait_done("rerun_done", 500);
    check("rerun_writes", n_wr - base_wr, 4);
    check("rerun_exp", {8'd0, exp_r, exp_g, exp_b}, {8'd0, 8'd59, 8'd66, 8'd72});
    start = 1'b0;
    tick();

    // Frame 5: all-255 frame, 16 blocks
    start_b = 1'b1;
    k = 0;
    while (!done_b && k < 2000) begin tick(); k++; end
    check("big_done", {31'd0, done_b}, 1);
    check("big_acc_r", {12'd0, dut_b.u_accum.acc_r}, 4080);
    check("big_acc_g", {12'd0, dut_b.u_accum.acc_g}, 4080);
    check("big_acc_b", {12'd0, dut_b.u_accum.acc_b}, 4080);
    check("big_exp", {8'd0, exp_r_b, exp_g_b, exp_b_b}, 32'h00FFFFFF);
    check("big_no_error", {31'd0, error_b}, 0);
    start_b = 1'b0;
    tick();
    check("big_done_fall", {31'd0, done_b}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
